// File: rtl/pim_tile_scheduler.sv
// Command sequencer for the PIM matrix multiply: walks every (output tile, reduction chunk)
// pair of C = A*B and issues one valid/ready command per pair with unit id and base addresses.
module pim_tile_scheduler #(
  parameter int MATRIX_SIZE       = 4,
  parameter int NUM_PIM_UNITS     = 4,
  parameter int PIM_UNIT_CAPACITY = 2,
  parameter int LEN               = 10,
  localparam int UID_W = (NUM_PIM_UNITS > 1) ? $clog2(NUM_PIM_UNITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  input  logic [LEN-1:0]   a_base,
  input  logic [LEN-1:0]   b_base,
  input  logic [LEN-1:0]   c_base,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [UID_W-1:0] cmd_unit,
  output logic [LEN-1:0]   cmd_a_addr,
  output logic [LEN-1:0]   cmd_b_addr,
  output logic [LEN-1:0]   cmd_c_addr,
  output logic             cmd_first_k,
  output logic             cmd_last_k,
  output logic             busy,
  output logic             done
);

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    for (int i = 1; i <= v; i++) begin
      if (i * i <= v) r = i;
    end
    return r;
  endfunction

  localparam int GRID    = isqrt(NUM_PIM_UNITS);
  localparam int CHUNK   = (GRID > 0) ? MATRIX_SIZE / GRID : 0;
  localparam int K_STEPS = (PIM_UNIT_CAPACITY > 0) ? MATRIX_SIZE / PIM_UNIT_CAPACITY : 0;
  localparam int TW      = (GRID > 1) ? $clog2(GRID) : 1;
  localparam int KW      = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;

  generate
    if (NUM_PIM_UNITS < 1 || GRID * GRID != NUM_PIM_UNITS || MATRIX_SIZE < 1 ||
        GRID > MATRIX_SIZE || ((GRID > 0) ? (MATRIX_SIZE % GRID) : 1) != 0 ||
        PIM_UNIT_CAPACITY < 1 ||
        ((PIM_UNIT_CAPACITY > 0) ? (MATRIX_SIZE % PIM_UNIT_CAPACITY) : 1) != 0 ||
        LEN < 1) begin : g_bad_params
      $error("pim_tile_scheduler: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   ti_q, ti_d, tj_q, tj_d;
  logic [KW-1:0]   k_q, k_d;
  logic            mode_q, mode_d;
  logic [LEN-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;

  logic last_ti, last_tj, last_k;
  assign last_ti = (ti_q == TW'(GRID - 1));
  assign last_tj = (tj_q == TW'(GRID - 1));
  assign last_k  = (k_q == KW'(K_STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ti_q    <= '0;
      tj_q    <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      ti_q    <= ti_d;
      tj_q    <= tj_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  // mode 0 nests ti/tj/k (k fastest); mode 1 nests k/ti/tj (tj fastest)
  always_comb begin
    state_d = state_q;
    ti_d    = ti_q;
    tj_d    = tj_q;
    k_d     = k_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ISSUE;
          mode_d  = mode;
          a_d     = a_base;
          b_d     = b_base;
          c_d     = c_base;
          ti_d    = '0;
          tj_d    = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          if (last_ti && last_tj && last_k) begin
            state_d = DONE;
          end else if (!mode_q) begin
            if (!last_k) begin
              k_d = k_q + KW'(1);
            end else begin
              k_d = '0;
              if (!last_tj) begin
                tj_d = tj_q + TW'(1);
              end else begin
                tj_d = '0;
                ti_d = ti_q + TW'(1);
              end
            end
          end else begin
            if (!last_tj) begin
              tj_d = tj_q + TW'(1);
            end else begin
              tj_d = '0;
              if (!last_ti) begin
                ti_d = ti_q + TW'(1);
              end else begin
                ti_d = '0;
                k_d  = k_q + KW'(1);
              end
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  assign cmd_valid = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Fields are forced to zero outside ISSUE so idle/reset outputs read as all-zero
  assign cmd_unit    = cmd_valid ? (UID_W'(ti_q) * UID_W'(GRID) + UID_W'(tj_q)) : '0;
  assign cmd_a_addr  = cmd_valid ? (a_q + LEN'(ti_q) * LEN'(CHUNK * MATRIX_SIZE)
                                       + LEN'(k_q) * LEN'(PIM_UNIT_CAPACITY)) : '0;
  assign cmd_b_addr  = cmd_valid ? (b_q + LEN'(k_q) * LEN'(PIM_UNIT_CAPACITY * MATRIX_SIZE)
                                       + LEN'(tj_q) * LEN'(CHUNK)) : '0;
  assign cmd_c_addr  = cmd_valid ? (c_q + LEN'(ti_q) * LEN'(CHUNK * MATRIX_SIZE)
                                       + LEN'(tj_q) * LEN'(CHUNK)) : '0;
  assign cmd_first_k = cmd_valid && (k_q == '0);
  assign cmd_last_k  = cmd_valid && last_k;

endmodule

// File: tb/tb_pim_tile_scheduler.sv
// Randomised self-checking bench: two scheduler configurations (2x2 grid N=4, 4x4 grid N=8)
// compared against a loop-nest reference model of the command sequence.
module tb_pim_tile_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, mode = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [9:0] aBase = '0, bBase = '0, cBase = '0;
  int         sel = 0;

  logic       start1, start2;
  assign start1 = start && (sel == 0);
  assign start2 = start && (sel == 1);

  logic       v1, f1, l1, busy1, done1, v2, f2, l2, busy2, done2;
  logic [1:0] u1;
  logic [3:0] u2;
  logic [9:0] a1, b1, c1, a2, b2, c2;

  pim_tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .abort(abort),
    .a_base(aBase), .b_base(bBase), .c_base(cBase),
    .cmd_valid(v1), .cmd_ready(ready), .cmd_unit(u1),
    .cmd_a_addr(a1), .cmd_b_addr(b1), .cmd_c_addr(c1),
    .cmd_first_k(f1), .cmd_last_k(l1), .busy(busy1), .done(done1)
  );

  pim_tile_scheduler #(.MATRIX_SIZE(8), .NUM_PIM_UNITS(16), .PIM_UNIT_CAPACITY(4), .LEN(10)) dutBig (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .abort(abort),
    .a_base(aBase), .b_base(bBase), .c_base(cBase),
    .cmd_valid(v2), .cmd_ready(ready), .cmd_unit(u2),
    .cmd_a_addr(a2), .cmd_b_addr(b2), .cmd_c_addr(c2),
    .cmd_first_k(f2), .cmd_last_k(l2), .busy(busy2), .done(done2)
  );

  typedef struct packed {
    logic [31:0] unit;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        isFirst;
    logic        isLast;
  } cmd_t;

  logic        mValid, mBusy, mDone, mFirst, mLast;
  logic [31:0] mUnit, mA, mB, mC;
  assign mValid = (sel == 0) ? v1 : v2;
  assign mBusy  = (sel == 0) ? busy1 : busy2;
  assign mDone  = (sel == 0) ? done1 : done2;
  assign mFirst = (sel == 0) ? f1 : f2;
  assign mLast  = (sel == 0) ? l1 : l2;
  assign mUnit  = (sel == 0) ? 32'(u1) : 32'(u2);
  assign mA     = (sel == 0) ? 32'(a1) : 32'(a2);
  assign mB     = (sel == 0) ? 32'(b1) : 32'(b2);
  assign mC     = (sel == 0) ? 32'(c1) : 32'(c2);

  cmd_t cur;
  assign cur = {mUnit, mA, mB, mC, mFirst, mLast};

  int   checks = 0;
  int   passes = 0;
  cmd_t got[$];
  cmd_t exp[$];
  int   doneSeen = 0;
  int   jobBase = 0;
  cmd_t prevCmd;
  logic prevStall = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Handshakes are recorded at the falling edge preceding the rising edge that takes them
  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall <= 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("validHold", 32'(mValid), 32'd1);
        checkOutput("stableUnit", cur.unit, prevCmd.unit);
        checkOutput("stableA", cur.a, prevCmd.a);
        checkOutput("stableB", cur.b, prevCmd.b);
        checkOutput("stableC", cur.c, prevCmd.c);
        checkOutput("stableFlags", 32'({cur.isFirst, cur.isLast}), 32'({prevCmd.isFirst, prevCmd.isLast}));
      end
      if (mValid && ready) got.push_back(cur);
      if (mDone) doneSeen <= doneSeen + 1;
      prevStall <= mValid && !ready && !abort;
      prevCmd   <= cur;
    end
  end

  // Reference: the two loop nests written directly from the address formulas
  task automatic fillExpected(input int s, input logic m, input int ab, input int bb, input int cb);
    int g, ch, n, cap, ks;
    cmd_t e;
    g   = (s == 0) ? 2 : 4;
    n   = (s == 0) ? 4 : 8;
    cap = (s == 0) ? 2 : 4;
    ch  = n / g;
    ks  = n / cap;
    exp.delete();
    for (int outer = 0; outer < ((m == 0) ? g : ks); outer++)
      for (int mid = 0; mid < g; mid++)
        for (int inner = 0; inner < ((m == 0) ? ks : g); inner++) begin
          int ti, tj, k;
          ti = (m == 0) ? outer : mid;
          tj = (m == 0) ? mid : inner;
          k  = (m == 0) ? inner : outer;
          e.unit    = ti * g + tj;
          e.a       = (ab + ti * ch * n + k * cap) % 1024;
          e.b       = (bb + k * cap * n + tj * ch) % 1024;
          e.c       = (cb + ti * ch * n + tj * ch) % 1024;
          e.isFirst = (k == 0);
          e.isLast  = (k == ks - 1);
          exp.push_back(e);
        end
  endtask

  task automatic applyStimulus(input int s, input logic m, input logic [9:0] ab, input logic [9:0] bb,
                               input logic [9:0] cb, input bit randReady, input int abortAfter,
                               input bit busyPulse, input string name);
    int  total, doneBase, expCount, gotCount;
    bit  finished;
    sel = s;
    fillExpected(s, m, int'(ab), int'(bb), int'(cb));
    total    = exp.size();
    jobBase  = got.size();
    doneBase = doneSeen;
    @(posedge clk); #1;
    start = 1'b1; mode = m; aBase = ab; bBase = bb; cBase = cb;
    @(posedge clk); #1;
    start = 1'b0;
    ready = randReady ? ($urandom_range(0, 99) < 40) : 1'b1;
    checkOutput({name, "_startValid"}, 32'(mValid), 32'd1);
    checkOutput({name, "_startBusy"}, 32'(mBusy), 32'd1);
    finished = 0;
    for (int n = 1; n <= 400 && !finished; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (abortAfter >= 0 && got.size() - jobBase == abortAfter) begin
        abort = 1'b1; ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput({name, "_abortValid"}, 32'(mValid), 32'd0);
        checkOutput({name, "_abortBusy"}, 32'(mBusy), 32'd0);
        finished = 1;
      end else if (mDone) begin
        checkOutput({name, "_busyInDone"}, 32'(mBusy), 32'd1);
        checkOutput({name, "_doneValid"}, 32'(mValid), 32'd0);
        if (!randReady) checkOutput({name, "_doneLatency"}, 32'(n), 32'(total));
        ready = 1'b0;
        @(posedge clk); #1;
        checkOutput({name, "_donePulse"}, 32'(mDone), 32'd0);
        checkOutput({name, "_idleBusy"}, 32'(mBusy), 32'd0);
        finished = 1;
      end else begin
        if (busyPulse && n == 2) begin
          start = 1'b1; mode = ~m;
          aBase = ab + 10'd100; bBase = bb + 10'd7; cBase = cb + 10'd9;
        end
        ready = randReady ? ($urandom_range(0, 99) < 40) : 1'b1;
      end
    end
    if (!finished) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    expCount = (abortAfter >= 0) ? abortAfter : total;
    gotCount = got.size() - jobBase;
    checkOutput({name, "_count"}, 32'(gotCount), 32'(expCount));
    checkOutput({name, "_doneCount"}, 32'(doneSeen - doneBase), (abortAfter >= 0) ? 32'd0 : 32'd1);
    for (int i = 0; i < expCount && i < gotCount; i++) begin
      checkOutput($sformatf("%s_c%0d_unit", name, i), got[jobBase + i].unit, exp[i].unit);
      checkOutput($sformatf("%s_c%0d_a", name, i), got[jobBase + i].a, exp[i].a);
      checkOutput($sformatf("%s_c%0d_b", name, i), got[jobBase + i].b, exp[i].b);
      checkOutput($sformatf("%s_c%0d_c", name, i), got[jobBase + i].c, exp[i].c);
      checkOutput($sformatf("%s_c%0d_first", name, i), 32'(got[jobBase + i].isFirst), 32'(exp[i].isFirst));
      checkOutput($sformatf("%s_c%0d_last", name, i), 32'(got[jobBase + i].isLast), 32'(exp[i].isLast));
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_valid"}, 32'(mValid), 32'd0);
    checkOutput({name, "_busy"}, 32'(mBusy), 32'd0);
    checkOutput({name, "_done"}, 32'(mDone), 32'd0);
    checkOutput({name, "_unit"}, mUnit, 32'd0);
    checkOutput({name, "_a"}, mA, 32'd0);
    checkOutput({name, "_b"}, mB, 32'd0);
    checkOutput({name, "_c"}, mC, 32'd0);
    checkOutput({name, "_flags"}, 32'({mFirst, mLast}), 32'd0);
  endtask

  int tbl [8][6];

  initial begin
    tbl = '{'{0, 0, 16, 32, 1, 0}, '{0, 2, 24, 32, 0, 1}, '{1, 0, 18, 34, 1, 0}, '{1, 2, 26, 34, 0, 1},
            '{2, 8, 16, 40, 1, 0}, '{2, 10, 24, 40, 0, 1}, '{3, 8, 18, 42, 1, 0}, '{3, 10, 26, 42, 0, 1}};
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;

    applyStimulus(0, 1'b0, 10'd0, 10'd16, 10'd32, 0, -1, 0, "m0");
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("tbl%0d_unit", i), got[jobBase + i].unit, 32'(tbl[i][0]));
      checkOutput($sformatf("tbl%0d_a", i), got[jobBase + i].a, 32'(tbl[i][1]));
      checkOutput($sformatf("tbl%0d_b", i), got[jobBase + i].b, 32'(tbl[i][2]));
      checkOutput($sformatf("tbl%0d_c", i), got[jobBase + i].c, 32'(tbl[i][3]));
      checkOutput($sformatf("tbl%0d_fl", i), 32'({got[jobBase + i].isFirst, got[jobBase + i].isLast}),
                  32'(tbl[i][4] * 2 + tbl[i][5]));
    end

    applyStimulus(0, 1'b1, 10'd0, 10'd16, 10'd32, 0, -1, 0, "m1");
    applyStimulus(0, 1'b0, 10'd0, 10'd16, 10'd32, 1, -1, 0, "randReady");
    applyStimulus(0, 1'b0, 10'd0, 10'd16, 10'd32, 0, 3, 0, "abort");
    applyStimulus(0, 1'b0, 10'd0, 10'd16, 10'd32, 0, -1, 0, "replay");
    applyStimulus(0, 1'b0, 10'd1020, 10'd16, 10'd32, 0, -1, 1, "wrap");
    checkOutput("wrap_cmd8_a", got[jobBase + 7].a, 32'd6);

    applyStimulus(1, 1'b0, 10'd100, 10'd200, 10'd300, 0, -1, 0, "big");
    checkOutput("big_lastUnit", got[jobBase + 31].unit, 32'd15);
    checkOutput("big_lastA", got[jobBase + 31].a, 32'd152);
    checkOutput("big_lastB", got[jobBase + 31].b, 32'd238);
    checkOutput("big_lastC", got[jobBase + 31].c, 32'd354);
    applyStimulus(1, 1'b1, 10'($urandom), 10'($urandom), 10'($urandom), 1, -1, 0, "bigK");

    for (int j = 0; j < 4; j++)
      applyStimulus($urandom_range(0, 1), 1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom),
                    10'($urandom), 1, -1, 0, $sformatf("rand%0d", j));

    sel = 1;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; aBase = 10'd5; bBase = 10'd6; cBase = 10'd7;
    @(posedge clk); #1;
    start = 1'b0; ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("midJobBusy", 32'(mBusy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkAllZero("midReset");
    @(posedge clk); #1;
    ready = 1'b0;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
